// File: rtl/noc_output_arbiter_pkg.sv
// Shared NoC flit types, arbiter state encoding and the round-robin pick helper.
package noc_output_arbiter_pkg;

    localparam int N_PORTS    = 5;
    localparam int PORT_IDX_W = $clog2(N_PORTS);
    localparam int TAIL_LEN_W = 4;
    localparam int DEST_W     = 4;
    localparam int PAYLOAD_W  = 16;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2
    } flit_type_e;

    typedef struct packed {
        logic [TAIL_LEN_W-1:0] tail_length;
        logic [DEST_W-1:0]     dest;
    } flit_hdr_info_t;

    typedef struct packed {
        flit_type_e             ftype;
        flit_hdr_info_t         hdr_info;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // First requester at or above ptr, wrapping past the last port.
    function automatic logic [PORT_IDX_W-1:0] rr_pick(input logic [N_PORTS-1:0]    req,
                                                      input logic [PORT_IDX_W-1:0] ptr);
        logic [PORT_IDX_W-1:0] win;
        logic [PORT_IDX_W:0]   sum;
        logic                  found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            sum = {1'b0, ptr} + (PORT_IDX_W+1)'(k);
            if (sum >= (PORT_IDX_W+1)'(N_PORTS)) begin
                sum = sum - (PORT_IDX_W+1)'(N_PORTS);
            end else begin
                sum = sum;
            end
            if (!found && req[sum[PORT_IDX_W-1:0]]) begin
                found = 1'b1;
                win   = sum[PORT_IDX_W-1:0];
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_arbiter.sv
// Round-robin picker: request vector plus pointer gives winner index and any-valid.
module rr_arbiter #(
    parameter int N_IN  = 5,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_valid
);

    // Upward search from ptr with wrap; the first hit wins.
    always_comb begin
        logic [IDX_W:0] sum;
        sum       = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_IN)) begin
                sum = sum - (IDX_W+1)'(N_IN);
            end else begin
                sum = sum;
            end
            if (!any_valid && req[sum[IDX_W-1:0]]) begin
                any_valid = 1'b1;
                grant_idx = sum[IDX_W-1:0];
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output arbiter: round-robin over header flits, link locked until packet end.
// Optional protocol checker with sticky err output is enabled by NOC_ARB_CHECK_EN.
module noc_output_arbiter
    import noc_output_arbiter_pkg::*;
#(
    parameter int N_IN  = N_PORTS,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in_valid,
    input  flit_t            in_flit [N_IN],
    output logic [N_IN-1:0]  in_ready,
    output logic             out_valid,
    output flit_t            out_flit,
    input  logic             out_ready,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
`ifdef NOC_ARB_CHECK_EN
    ,
    output logic             err
`endif
);

    arb_state_e            state_r, state_n;
    logic [IDX_W-1:0]      rr_ptr_r, rr_ptr_n, grant_idx_r, grant_idx_n, winner_s;
    logic [TAIL_LEN_W-1:0] rem_cnt_r, rem_cnt_n;
    logic                  hdr_done_r, hdr_done_n;
    logic                  any_cand_s, sel_valid_s, sel_is_hdr_s, xfer_s;
    logic [N_IN-1:0]       cand_s;
    flit_t                 sel_flit_s;

    for (genvar g = 0; g < N_IN; g++) begin : g_port
        assign cand_s[g]   = in_valid[g] && (in_flit[g].ftype == FLIT_HEADER);
        assign in_ready[g] = busy && out_ready && (grant_idx_r == IDX_W'(g));
    end

    rr_arbiter #(.N_IN(N_IN), .IDX_W(IDX_W)) u_rr (
        .req       (cand_s),
        .ptr       (rr_ptr_r),
        .grant_idx (winner_s),
        .any_valid (any_cand_s)
    );

    assign busy         = (state_r == ARB_LOCKED);
    assign grant_idx    = grant_idx_r;
    assign sel_flit_s   = in_flit[grant_idx_r];
    assign sel_valid_s  = in_valid[grant_idx_r];
    assign sel_is_hdr_s = (sel_flit_s.ftype == FLIT_HEADER);
    assign out_valid    = busy && sel_valid_s;
    assign out_flit     = busy ? sel_flit_s : '0;
    assign xfer_s       = out_valid && out_ready;

    // Arbitration in IDLE, packet length tracking and release in LOCKED.
    always_comb begin
        state_n     = state_r;
        rr_ptr_n    = rr_ptr_r;
        grant_idx_n = grant_idx_r;
        rem_cnt_n   = rem_cnt_r;
        hdr_done_n  = hdr_done_r;
        case (state_r)
            ARB_IDLE: begin
                if (any_cand_s) begin
                    grant_idx_n = winner_s;
                    rr_ptr_n    = (winner_s == IDX_W'(N_IN-1)) ? '0 : winner_s + IDX_W'(1);
                    hdr_done_n  = 1'b0;
                    state_n     = ARB_LOCKED;
                end else begin
                    state_n = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (xfer_s && sel_is_hdr_s) begin
                    rem_cnt_n  = sel_flit_s.hdr_info.tail_length;
                    hdr_done_n = 1'b1;
                    if (sel_flit_s.hdr_info.tail_length == TAIL_LEN_W'(0)) begin
                        state_n = ARB_IDLE;
                    end else begin
                        state_n = ARB_LOCKED;
                    end
                end else if (xfer_s) begin
                    // Release at 1 so the counter never wraps below zero.
                    if (rem_cnt_r == TAIL_LEN_W'(1)) begin
                        rem_cnt_n = '0;
                        state_n   = ARB_IDLE;
                    end else if (rem_cnt_r != TAIL_LEN_W'(0)) begin
                        rem_cnt_n = rem_cnt_r - TAIL_LEN_W'(1);
                    end else begin
                        rem_cnt_n = rem_cnt_r;
                    end
                end else begin
                    state_n = ARB_LOCKED;
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ARB_IDLE;
            rr_ptr_r    <= '0;
            grant_idx_r <= '0;
            rem_cnt_r   <= '0;
            hdr_done_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            rr_ptr_r    <= rr_ptr_n;
            grant_idx_r <= grant_idx_n;
            rem_cnt_r   <= rem_cnt_n;
            hdr_done_r  <= hdr_done_n;
        end
    end

`ifdef NOC_ARB_CHECK_EN
    logic [N_IN-1:0] non_hdr_s;
    logic            err_r, err_set_s;

    for (genvar g = 0; g < N_IN; g++) begin : g_chk
        assign non_hdr_s[g] = in_valid[g] && (in_flit[g].ftype != FLIT_HEADER);
    end

    assign err_set_s = ((state_r == ARB_IDLE) && (|non_hdr_s)) ||
                       ((state_r == ARB_LOCKED) && hdr_done_r && xfer_s && sel_is_hdr_s);
    assign err = err_r;

    // Sticky protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
            $display("noc_output_arbiter: flit order violation, state=%0d", state_r);
        end else begin
            err_r <= err_r;
        end
    end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed self-checking bench for noc_output_arbiter (err checks when NOC_ARB_CHECK_EN set).
module tb_noc_output_arbiter;
    import noc_output_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  in_valid;
    flit_t       in_flit [5];
    logic [4:0]  in_ready;
    logic        out_valid;
    flit_t       out_flit;
    logic        out_ready;
    logic        busy;
    logic [2:0]  grant_idx;
`ifdef NOC_ARB_CHECK_EN
    logic        err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int log_n  = 0;
    logic [2:0]  log_grant [32];
    flit_t       log_flit  [32];
    int          log_cyc   [32];
    flit_t       src_mem   [5][16];
    int          src_head  [5];
    int          src_tail  [5];

    noc_output_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .busy      (busy),
        .grant_idx (grant_idx)
`ifdef NOC_ARB_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk_hdr(input logic [3:0] tl, input logic [15:0] p);
        flit_t f;
        f.ftype                = FLIT_HEADER;
        f.hdr_info.tail_length = tl;
        f.hdr_info.dest        = 4'd0;
        f.payload              = p;
        return f;
    endfunction

    function automatic flit_t mk_body(input logic [15:0] p, input logic last);
        flit_t f;
        f.ftype    = last ? FLIT_TAIL : FLIT_BODY;
        f.hdr_info = '0;
        f.payload  = p;
        return f;
    endfunction

    task automatic push(input int i, input flit_t f);
        src_mem[i][src_tail[i]] = f;
        src_tail[i]++;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 5; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
    endtask

    task automatic present();
        for (int i = 0; i < 5; i++) begin
            if (src_head[i] < src_tail[i]) begin
                in_valid[i] = 1'b1;
                in_flit[i]  = src_mem[i][src_head[i]];
            end else begin
                in_valid[i] = 1'b0;
                in_flit[i]  = '0;
            end
        end
    endtask

    // One clock: log any transfer, advance, pop consumed source flits.
    task automatic cycle();
        logic [4:0] rdy;
        #1;
        rdy = in_ready & in_valid;
        if (out_valid && out_ready && log_n < 32) begin
            log_grant[log_n] = grant_idx;
            log_flit[log_n]  = out_flit;
            log_cyc[log_n]   = cyc;
            log_n++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 5; i++) begin
            if (rdy[i]) src_head[i]++;
        end
        present();
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        clear_src();
        present();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        present();
        #1;
        cyc   = 0;
        log_n = 0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        clear_src();
        present();
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (grant_idx !== 3'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_idx); end
        checks++;
        if (in_ready !== 5'b00000) begin errors++; $display("FAIL reset_in_ready got=%b exp=00000", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_flit !== flit_t'(0)) begin errors++; $display("FAIL reset_out_flit got=%h exp=0", out_flit); end
    endtask

    task automatic test_single();
        flit_t h;
        do_reset();
        h = mk_hdr(4'd0, 16'h02A0);
        push(2, h);
        present();
        #1;
        checks++;
        if (in_ready !== 5'b00000 || busy !== 1'b0) begin
            errors++; $display("FAIL single_c0 in_ready=%b busy=%b exp 00000/0", in_ready, busy);
        end
        cycle();
        checks++;
        if (busy !== 1'b1 || grant_idx !== 3'd2) begin
            errors++; $display("FAIL single_c1_grant busy=%b grant=%0d exp 1/2", busy, grant_idx);
        end
        checks++;
        if (in_ready !== 5'b00100 || out_flit !== h || out_valid !== 1'b1) begin
            errors++; $display("FAIL single_c1_data in_ready=%b flit=%h exp 00100/%h", in_ready, out_flit, h);
        end
        cycle();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_c2 busy=%b out_valid=%b exp 0/0", busy, out_valid);
        end
    endtask

    task automatic test_two_packets();
        logic [2:0]  eg;
        int          ec;
        logic [15:0] ep;
        do_reset();
        push(0, mk_hdr(4'd2, 16'h00A0)); push(0, mk_body(16'h00A1, 1'b0)); push(0, mk_body(16'h00A2, 1'b1));
        push(3, mk_hdr(4'd2, 16'h03A0)); push(3, mk_body(16'h03A1, 1'b0)); push(3, mk_body(16'h03A2, 1'b1));
        present();
        #1;
        for (int c = 0; c < 10; c++) cycle();
        checks++;
        if (log_n !== 6) begin errors++; $display("FAIL two_pkt_count got=%0d exp=6", log_n); end
        for (int k = 0; k < 6; k++) begin
            eg = (k < 3) ? 3'd0 : 3'd3;
            ec = (k < 3) ? k + 1 : k + 2;
            ep = ((k < 3) ? 16'h00A0 : 16'h03A0) + 16'(k % 3);
            checks++;
            if (log_grant[k] !== eg || log_cyc[k] !== ec || log_flit[k].payload !== ep) begin
                errors++;
                $display("FAIL two_pkt_xfer%0d got g=%0d c=%0d p=%h exp g=%0d c=%0d p=%h",
                         k, log_grant[k], log_cyc[k], log_flit[k].payload, eg, ec, ep);
            end
        end
    endtask

    task automatic test_fairness();
        logic [15:0] ep;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) push(i, mk_hdr(4'd0, 16'(i * 256 + r)));
        end
        present();
        #1;
        for (int c = 0; c < 22; c++) cycle();
        checks++;
        if (log_n !== 10) begin errors++; $display("FAIL rr_count got=%0d exp=10", log_n); end
        for (int k = 0; k < 10; k++) begin
            ep = 16'((k % 5) * 256 + k / 5);
            checks++;
            if (log_grant[k] !== 3'(k % 5) || log_cyc[k] !== 2 * k + 1 || log_flit[k].payload !== ep) begin
                errors++;
                $display("FAIL rr_order%0d got g=%0d c=%0d p=%h exp g=%0d c=%0d p=%h",
                         k, log_grant[k], log_cyc[k], log_flit[k].payload, k % 5, 2 * k + 1, ep);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int         exp_c;
        pat = 4'b1001;
        do_reset();
        push(1, mk_hdr(4'd3, 16'h01B0)); push(1, mk_body(16'h01B1, 1'b0));
        push(1, mk_body(16'h01B2, 1'b0)); push(1, mk_body(16'h01B3, 1'b1));
        present();
        #1;
        for (int c = 0; c < 11; c++) begin
            out_ready = pat[c % 4];
            checks++;
            if (busy !== ((c >= 1 && c <= 8) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL bp_busy_c%0d got=%b", c, busy);
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (dut.rem_cnt_r !== 4'd2) begin
                    errors++; $display("FAIL bp_rem_hold_c%0d got=%0d exp=2", c, dut.rem_cnt_r);
                end
            end
            cycle();
        end
        out_ready = 1'b1;
        checks++;
        if (log_n !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", log_n); end
        for (int k = 0; k < 4; k++) begin
            exp_c = (k < 2) ? 3 + k : 5 + k;
            checks++;
            if (log_grant[k] !== 3'd1 || log_cyc[k] !== exp_c || log_flit[k].payload !== 16'h01B0 + 16'(k)) begin
                errors++;
                $display("FAIL bp_xfer%0d got g=%0d c=%0d p=%h exp g=1 c=%0d p=%h",
                         k, log_grant[k], log_cyc[k], log_flit[k].payload, exp_c, 16'h01B0 + 16'(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        flit_t h4;
        do_reset();
        push(1, mk_hdr(4'd3, 16'h02C0)); push(1, mk_body(16'h02C1, 1'b0));
        push(1, mk_body(16'h02C2, 1'b0)); push(1, mk_body(16'h02C3, 1'b1));
        present();
        #1;
        for (int c = 0; c < 3; c++) cycle();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre busy=%b out_valid=%b exp 1/1", busy, out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || grant_idx !== 3'd0 || in_ready !== 5'b0 || out_valid !== 1'b0 || out_flit !== flit_t'(0)) begin
            errors++;
            $display("FAIL mid_async busy=%b grant=%0d in_ready=%b out_valid=%b flit=%h exp all zero",
                     busy, grant_idx, in_ready, out_valid, out_flit);
        end
        checks++;
        if (dut.rr_ptr_r !== 3'd0) begin errors++; $display("FAIL mid_rr_ptr got=%0d exp=0", dut.rr_ptr_r); end
        @(posedge clk);
        #1;
        clear_src();
        h4 = mk_hdr(4'd0, 16'h04D0);
        push(4, h4);
        present();
        #1;
        rst = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b1 || grant_idx !== 3'd4 || in_ready !== 5'b10000 || out_flit !== h4) begin
            errors++;
            $display("FAIL mid_regrant busy=%b grant=%0d in_ready=%b flit=%h exp 1/4/10000/%h",
                     busy, grant_idx, in_ready, out_flit, h4);
        end
        cycle();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_release busy=%b exp=0", busy); end
    endtask

    task automatic test_idle_body();
        do_reset();
        push(0, mk_body(16'h0055, 1'b0));
        present();
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy !== 1'b0 || in_ready !== 5'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_body_c%0d busy=%b in_ready=%b out_valid=%b exp 0/00000/0",
                         c, busy, in_ready, out_valid);
            end
            cycle();
        end
    endtask

`ifdef NOC_ARB_CHECK_EN
    task automatic test_check_err();
        do_reset();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_reset got=%b exp=0", err); end
        push(0, mk_body(16'h0066, 1'b0));
        present();
        #1;
        cycle();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_idle_body got=%b exp=1", err); end
        clear_src();
        present();
        cycle();
        cycle();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        do_reset();
        push(0, mk_hdr(4'd2, 16'h0070)); push(0, mk_hdr(4'd0, 16'h0071));
        present();
        #1;
        cycle();
        cycle();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_first_hdr got=%b exp=0", err); end
        cycle();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_second_hdr got=%b exp=1", err); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 5'b0;
        for (int i = 0; i < 5; i++) in_flit[i] = '0;
        test_reset();
        test_single();
        test_two_packets();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_idle_body();
`ifdef NOC_ARB_CHECK_EN
        test_check_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port wormhole arbiter for a mesh router. One instance sits in front of each router output direction.
- Shares the output link between N_IN input ports. It picks a packet by round-robin over requesting header flits and locks the link to the winner until the packet's last flit has passed.
- Packet length comes from the header's flit_hdr_info.tail_length field: the number of non-header flits that follow the header.

Parameters:
- N_IN, 5, number of requesting input ports (N, S, E, W, LOCAL).
- IDX_W, $clog2(N_IN), width of the winner index and round-robin pointer.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  N_IN  per-input: head flit is valid and routed to this output.
- in_flit  in  N_IN x flit_t  per-input head flit (noc_types::flit_t).
- in_ready  out  N_IN  per-input: head flit is consumed this cycle; at most one bit set.
- out_valid  out  1  output flit valid.
- out_flit  out  flit_t  output flit.
- out_ready  in  1  downstream accepts flit.
- busy  out  1  link locked to a packet.
- grant_idx  out  IDX_W  current owner; meaningful only while busy.

Behaviour:
- Handshake: a transfer occurs on a cycle with out_valid && out_ready. in_ready[i] = busy && grant_idx==i && out_ready.
- Datapath is a combinational mux with zero latency while locked:
  - out_valid = busy && in_valid[grant_idx].
  - out_flit = in_flit[grant_idx] when busy, else 0.
- States: IDLE, LOCKED. busy = (state==LOCKED).
- IDLE:
  - Candidates are inputs with in_valid[i] and in_flit[i].type==HEADER.
  - Winner is the first candidate found searching upward, with wrap, from rr_ptr.
  - If any candidate exists: register grant_idx=winner, rr_ptr=(winner+1) mod N_IN, state->LOCKED.
  - This gives a 1-cycle arbitration bubble. No flit is consumed in IDLE.
- LOCKED:
  - Header transfer: load rem_cnt = header tail_length.
  - Header transfer with tail_length==0: state->IDLE on the next edge.
  - Non-header transfer: rem_cnt decrements. When a transfer occurs with rem_cnt==1, state->IDLE.
  - Header transfer and release are decided in the same cycle.
- rem_cnt width equals the tail_length field width in flit_hdr_info. It never underflows, because release happens at 1.
- Flit-order tracking: a flag hdr_done is cleared on entry to LOCKED and set on the header transfer. The first transfer while locked must be the header.
- Stall: out_ready low holds all state. in_valid low while locked gives out_valid low and no state change. The lock is never dropped mid-packet.
- After release, the next packet starts with the IDLE bubble. Back-to-back packets therefore cost one idle cycle each.
- Non-header flits presented in IDLE are ignored: no ready, no state change.
- Reset (asynchronous, any time, including mid-packet):
  - state=IDLE, rr_ptr=0, grant_idx=0, rem_cnt=0, hdr_done=0.
  - Outputs: in_ready=0, out_valid=0, out_flit=0, busy=0, grant_idx=0.
  - Any partially forwarded packet is abandoned.

Optional Feature:
- Macro NOC_ARB_CHECK_EN.
- Defined:
  - Extra port err (out, 1), reset 0, sticky until reset.
  - err sets when, in IDLE, some in_valid[i] has a non-HEADER flit.
  - err also sets when, in LOCKED with hdr_done=1, a HEADER flit is transferred.
  - A $display message is emitted on each set.
  - Datapath behaviour is unchanged.
- Undefined: no err port, no checking logic.

Decomposition:
- Add to noc_types:
  - arb_state_e {ARB_IDLE, ARB_LOCKED}.
  - TAIL_LEN_W constant tied to flit_hdr_info.tail_length.
  - N_PORTS=5.
- Add to noc_functions: a rr_pick(req, ptr) function returning the winner index.
- Natural sub-module: rr_arbiter (N_IN request vector + pointer -> one-hot/index winner, any-valid). It is reused by the router's input-side VC allocation.

Test Plan:
- Single header on input 2 with tail_length=0, out_ready=1:
  - Cycle 0 (IDLE): no ready.
  - Cycle 1: busy=1, grant_idx=2, out_flit=header, in_ready=5'b00100.
  - Cycle 2: busy=0.
- Headers on inputs 0 and 3 simultaneously, each with tail_length=2, then 2 body flits each:
  - Input 0 wins and transfers 3 flits.
  - 1 idle cycle.
  - Input 3 wins (rr_ptr=1) and transfers 3 flits. No interleaving.
- Round-robin fairness, all 5 inputs continuously offering single-flit packets: grant order 0,1,2,3,4,0, one flit every 2 cycles.
- Backpressure, header with tail_length=3 on input 1, out_ready toggling 1,0,0,1,...: exactly 4 transfers, rem_cnt holds during stalls, release after the 4th transfer.
- rst pulsed mid-packet (after header + 1 of 3 body flits): outputs go to reset values asynchronously. The next header on input 4 is granted with rr_ptr=0 search.
- With NOC_ARB_CHECK_EN:
  - Body flit on input 0 in IDLE -> err=1 and stays 1.
  - A second HEADER from the owner mid-packet -> err=1.
